// File: rtl/qam_rx_pkg.sv
// Shared constants and types for the PAM-4 symbol slicer and byte assembler.
// Gray mapping keeps adjacent amplitude levels one bit apart.
package qam_rx_pkg;

  localparam int SPS_DEFAULT = 16;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } slicer_state_t;

endpackage

// File: rtl/qam_pam4_slicer.sv
// Combinational PAM-4 decision: maps one signed sample to a Gray symbol.
// Compares at 17 bits so -32768 and the negated threshold stay representable.
module qam_pam4_slicer
  import qam_rx_pkg::*;
#(
  parameter logic signed [15:0] THRESH = 16'sd8192
) (
  input  logic signed [15:0] sample,
  output logic        [1:0]  sym
);

  logic signed [16:0] x_ext;
  logic signed [16:0] t_pos;
  logic signed [16:0] t_neg;

  assign x_ext = {sample[15], sample};
  assign t_pos = {THRESH[15], THRESH};
  assign t_neg = -t_pos;

  always_comb begin
    sym = SYM_M3;
    if (x_ext >= t_pos) begin
      sym = SYM_P3;
    end else if (x_ext >= 17'sd0) begin
      sym = SYM_P1;
    end else if (x_ext >= t_neg) begin
      sym = SYM_M1;
    end
  end

endmodule

// File: rtl/qam_symbol_slicer.sv
// Symbol timing, PAM-4 slicing and 4-symbol byte assembly with a one-deep
// output holding register and a sticky overflow flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | timing held: phase 0, symbol count 0, partial byte cleared
// ST_RUN  | phase free-runs 0..SPS-1, one sample per symbol at SAMPLE_OFFSET
module qam_symbol_slicer
  import qam_rx_pkg::*;
#(
  parameter int                 SPS           = SPS_DEFAULT,
  parameter int                 SAMPLE_OFFSET = 8,
  parameter logic signed [15:0] THRESH        = 16'sd8192
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] signal_in,
  input  logic               enable,
  input  logic               sync,
  output logic        [1:0]  sym_out,
  output logic               sym_valid,
  output logic        [7:0]  byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               overflow
);

  localparam int PW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SPS - 1);
  localparam logic [PW-1:0] SAMPLE_AT  = PW'(SAMPLE_OFFSET);

  slicer_state_t  state;
  logic [PW-1:0]  phase;
  logic [1:0]     sym_cnt;
  logic [5:0]     partial;

  logic [1:0]     slice_sym;
  logic           sample_hit;
  logic           byte_done;
  logic [7:0]     new_byte;

  qam_pam4_slicer #(
    .THRESH (THRESH)
  ) u_slicer (
    .sample (signal_in),
    .sym    (slice_sym)
  );

  // sync and a falling enable both pre-empt a coincident sample
  assign sample_hit = (state == ST_RUN) && enable && !sync && (phase == SAMPLE_AT);
  assign byte_done  = sample_hit && (sym_cnt == 2'd3);
  assign new_byte   = {partial, slice_sym};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      sym_cnt    <= 2'd0;
      partial    <= 6'd0;
      sym_out    <= 2'b00;
      sym_valid  <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sym_valid <= 1'b0;

      if (sync) begin
        overflow <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          phase   <= '0;
          sym_cnt <= 2'd0;
          partial <= 6'd0;
          if (enable) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state   <= ST_IDLE;
            phase   <= '0;
            sym_cnt <= 2'd0;
            partial <= 6'd0;
          end else if (sync) begin
            phase   <= '0;
            sym_cnt <= 2'd0;
            partial <= 6'd0;
          end else begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            if (sample_hit) begin
              sym_out   <= slice_sym;
              sym_valid <= 1'b1;
              sym_cnt   <= sym_cnt + 2'd1;
              partial   <= byte_done ? 6'd0 : {partial[3:0], slice_sym};
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A consumer taking the old byte in the completion cycle frees the slot.
      if (byte_done) begin
        if (!byte_valid || byte_ready) begin
          byte_out   <= new_byte;
          byte_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/qam_symbol_slicer.md
QAM_SYMBOL_SLICER -- requirements
Module: qam_symbol_slicer

Interface
REQ-001 SHALL have parameter SPS, default 16: clock cycles per symbol, 2..256.
REQ-002 SHALL have parameter SAMPLE_OFFSET, default 8: phase at which a symbol is sampled, 0..SPS-1.
REQ-003 SHALL have parameter THRESH, default 16'sd8192: positive outer-decision threshold.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port signal_in, input, 16 signed: filtered baseband sample from moving_avg_filt, one sample per cycle.
REQ-007 SHALL have port enable, input, 1: high runs symbol timing; low idles the block.
REQ-008 SHALL have port sync, input, 1: single-cycle symbol-phase realignment pulse.
REQ-009 SHALL have port sym_out, output, 2: Gray-coded PAM-4 decision.
REQ-010 SHALL have port sym_valid, output, 1: one-cycle strobe qualifying sym_out.
REQ-011 SHALL have port byte_out, output, 8: assembled byte, 4 symbols, first symbol in bits [7:6].
REQ-012 SHALL have port byte_valid, output, 1: byte_out holds an unconsumed byte.
REQ-013 SHALL have port byte_ready, input, 1: consumer accepts byte when high with byte_valid.
REQ-014 SHALL have port overflow, output, 1: sticky flag, a completed byte was dropped.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0.
REQ-016 In IDLE, phase counter and symbol count SHALL be held at 0, partial byte cleared, no sampling.
REQ-017 In RUN, phase SHALL count 0..SPS-1 and wrap to 0; sampling occurs in the cycle phase==SAMPLE_OFFSET.
REQ-018 Slicing of sampled x SHALL be: x>=THRESH->2'b10; 0<=x<THRESH->2'b11; -THRESH<=x<0->2'b01; x<-THRESH->2'b00.
REQ-019 Comparisons SHALL be 17-bit signed so x=-32768 and -THRESH do not overflow.
REQ-020 sym_out/sym_valid SHALL be registered: valid for exactly one cycle, the cycle after sampling.
REQ-021 Symbols SHALL shift into a 2-bit-per-symbol register MSB first; the 4th symbol completes a byte.
REQ-022 A completed byte SHALL appear on byte_out with byte_valid=1 in the same cycle as the 4th sym_valid.
REQ-023 byte_out SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-024 byte_valid SHALL clear the cycle after byte_valid&byte_ready, unless a new byte loads in that same cycle.
REQ-025 Byte completion while byte_valid=1 and byte_ready=0 SHALL drop the new byte and set overflow.
REQ-026 Byte completion while byte_valid=1 and byte_ready=1 SHALL load the new byte; byte_valid stays 1; no overflow.
REQ-027 sync=1 in RUN SHALL set phase to 0 next cycle, clear symbol count and partial byte, and clear overflow; a pending output byte is retained.
REQ-028 After sync, the first sample SHALL be taken SAMPLE_OFFSET cycles after the cycle following sync.
REQ-029 sync in IDLE SHALL clear overflow only.
REQ-030 A sync coinciding with a sampling cycle SHALL take priority: that sample is discarded.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state IDLE, phase 0, symbol count 0, sym_out 0, sym_valid 0, byte_out 0, byte_valid 0, overflow 0.
REQ-032 Release of rst_n SHALL take effect at the next posedge; reset mid-byte discards all partial and pending data.

Structure
REQ-033 Package qam_rx_pkg SHALL hold Gray symbol constants (SYM_M3=00, SYM_M1=01, SYM_P1=11, SYM_P3=10), default SPS, and the FSM state typedef.
REQ-034 Decision logic SHALL be a combinational sub-module qam_pam4_slicer (16-bit signed in, 2-bit out, THRESH parameter).

Verification (SPS=16, SAMPLE_OFFSET=8, THRESH=8192)
REQ-035 Assert rst_n=0 mid-run -> all outputs 0 immediately, no sym_valid for 9 cycles after release+enable.
REQ-036 enable=1, signal_in=12000 constant, byte_ready=1 -> sym_valid every 16 cycles, sym_out=10, byte_out=8'hAA after 4th symbol.
REQ-037 Sampled values 0, 8191, 8192, -1, -8192, -8193, -32768 -> 11, 11, 10, 01, 01, 00, 00.
REQ-038 byte_ready=0 across two byte completions -> first byte held stable, overflow=1, second byte lost; sync then clears overflow.
REQ-039 sync after 2 symbols -> partial discarded, next sample 9 cycles after sync, next byte built only from post-sync symbols.
REQ-040 Byte completes in the same cycle byte_ready=1 on pending byte -> new byte loaded, byte_valid continuous, overflow=0.
